actuator_driver: RTL and testbench
==================================

// Module: actuator_driver
// PURPOSE
//  Downstream of the washing-machine sequencer: consumes its one-hot-ish
//  ctrl_fill/ctrl_release/ctrl_forward/ctrl_reverse strobes and drives the
//  inlet/drain valves and the drum motor. Enforces valve mutual exclusion,
//  motor soft-start (PWM duty ramp) and a dead-time brake on stop or reversal,
//  and reports interlock violations on a sticky fault flag.
// PARAMETERS
//  PWM_WIDTH    8    width of PWM counter and duty register
//  DUTY_MAX     8'hF0 run duty; ramp saturates here (must be <= 2^PWM_WIDTH-1)
//  RAMP_STEP    8'h10 duty increment per ramp tick
//  RAMP_DIV     64   clk cycles per ramp tick (>=1)
//  DEADTIME_CYC 16   clk cycles motor held off in BRAKE (>=1)
//  FILL_TIMEOUT 4096 max continuous valve_in-open cycles (ACT_FILL_TIMEOUT_EN only)
// PORTS
//  clk           in   1  clock
//  rst_n         in   1  synchronous reset, active-low
//  ctrl_fill     in   1  request inlet valve open
//  ctrl_release  in   1  request drain valve open
//  ctrl_forward  in   1  request drum forward
//  ctrl_reverse  in   1  request drum reverse
//  clr_fault     in   1  clears fault/fault_code
//  valve_in      out  1  inlet valve drive
//  valve_out     out  1  drain valve drive
//  motor_en      out  1  motor bridge enable
//  motor_dir     out  1  1=forward, 0=reverse (valid while motor_en)
//  motor_pwm     out  1  motor PWM
//  fault         out  1  sticky, any fault_code bit set
//  fault_code    out  3  sticky: [0] fill&release, [1] fwd&rev, [2] fill timeout
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; duty=0; pwm_cnt=0; counters 0.
//  Valves (registered, 1-cycle latency): valve_in<=fill&~release;
//   valve_out<=release&~fill; fill&release -> both 0 next cycle, set code[0].
//  Motor FSM (registered; req = fwd^rev, conflict = fwd&rev sets code[1],
//   conflict counts as no request):
//   IDLE : en=0,duty=0. req -> RAMP, latch dir=fwd, ramp_cnt=0.
//   RAMP : en=1. every RAMP_DIV cycles duty<=min(duty+RAMP_STEP,DUTY_MAX)
//          (compute in PWM_WIDTH+1 bits, saturate); duty==DUTY_MAX -> RUN.
//          ~req or requested dir != latched dir -> BRAKE.
//   RUN  : en=1,duty=DUTY_MAX. ~req or dir change -> BRAKE.
//   BRAKE: en=0,duty=0, dead_cnt counts DEADTIME_CYC cycles, requests ignored,
//          then IDLE; a still-present req starts RAMP the cycle after.
//  Reversal therefore = RUN/RAMP -> BRAKE -> IDLE -> RAMP, never direct.
//  motor_en/motor_dir change only on FSM transitions; dir frozen outside IDLE.
//  PWM: pwm_cnt free-running, wraps 2^PWM_WIDTH-1 -> 0;
//   motor_pwm = motor_en & (pwm_cnt < duty), registered.
//  Faults: bits set on event, held until clr_fault; clr_fault and a new event
//   in the same cycle -> event wins (bit stays 1). fault = |fault_code.
//   Faults do not stop the motor; the interlocks themselves are the protection.
//  Reset mid-ramp/brake: immediate return to reset state next edge, no dead-time.
// CONFIGURATION
//  ACT_FILL_TIMEOUT_EN defined: fill_cnt counts cycles valve_in=1, cleared
//   when valve_in=0; reaching FILL_TIMEOUT forces valve_in=0, sets code[2];
//   inlet stays locked closed until ctrl_fill drops for >=1 cycle.
//  Not defined: no counter, code[2] tied 0, fill unlimited.
// TESTING
//  1 fill=1 for 5 cycles -> valve_in=1 from cycle 2 to 6; fill&release=1 ->
//    both valves 0 next cycle, fault=1, fault_code=3'b001 until clr_fault.
//  2 fwd=1 held, defaults -> RAMP, duty 0x10,0x20..0xF0 every 64 cycles,
//    RUN after 15 ticks (960 cycles); motor_pwm high 240 of every 256 cycles.
//  3 In RUN switch fwd->rev -> motor_en=0 for exactly 16 cycles, then
//    IDLE 1 cycle, RAMP with motor_dir=0 and duty restarting at 0.
//  4 fwd&rev both 1 in IDLE -> motor stays off, fault_code[1]=1; clr_fault with
//    conflict still present -> bit remains 1.
//  5 rst_n=0 during BRAKE and mid-RAMP -> next edge all outputs 0, IDLE.
//  6 ACT_FILL_TIMEOUT_EN, FILL_TIMEOUT=8, fill held -> valve_in open 8 cycles
//    then 0, code[2]=1; drop fill 1 cycle, reassert -> valve reopens.

Source files
------------

// File: rtl/actuator_if.sv
// Control strobes from the sequencer and the resulting valve/motor drives and fault flags.
// The sequencer side takes the master modport; the actuator driver takes the slave modport.
interface actuator_if;
    logic       ctrl_fill;
    logic       ctrl_release;
    logic       ctrl_forward;
    logic       ctrl_reverse;
    logic       clr_fault;
    logic       valve_in;
    logic       valve_out;
    logic       motor_en;
    logic       motor_dir;
    logic       motor_pwm;
    logic       fault;
    logic [2:0] fault_code;

    modport master (
        output ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, clr_fault,
        input  valve_in, valve_out, motor_en, motor_dir, motor_pwm, fault, fault_code
    );

    modport slave (
        input  ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, clr_fault,
        output valve_in, valve_out, motor_en, motor_dir, motor_pwm, fault, fault_code
    );
endinterface

// File: rtl/actuator_driver.sv
// Valve interlock, drum motor soft-start/dead-time brake FSM, PWM and sticky fault flags.
// Define ACT_FILL_TIMEOUT_EN to add the inlet fill timeout (FILL_TIMEOUT parameter, fault_code[2]).
//
// state    | meaning
// ST_IDLE  | motor off, duty 0, waiting for a single-direction request
// ST_RAMP  | motor on, duty stepping up by RAMP_STEP every RAMP_DIV cycles
// ST_RUN   | motor on at DUTY_MAX
// ST_BRAKE | motor off for DEADTIME_CYC cycles, requests ignored
module actuator_driver #(
    parameter int unsigned          PWM_WIDTH    = 8,
    parameter logic [PWM_WIDTH-1:0] DUTY_MAX     = 8'hF0,
    parameter logic [PWM_WIDTH-1:0] RAMP_STEP    = 8'h10,
    parameter int unsigned          RAMP_DIV     = 64,
    parameter int unsigned          DEADTIME_CYC = 16,
    parameter int unsigned          FILL_TIMEOUT = 4096
) (
    input  logic      clk,
    input  logic      rst_n,
    actuator_if.slave act
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RAMP  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_BRAKE = 2'd3;

    localparam int unsigned RAMP_W = $clog2(RAMP_DIV + 1);
    localparam int unsigned DEAD_W = $clog2(DEADTIME_CYC + 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYC - 1);

    logic fill;
    logic drain;
    logic fwd;
    logic rev;
    logic req;
    logic conflict;
    logic valve_clash;
    logic dir_change;
    logic ramp_tick;
    logic fill_block;
    logic fill_timeout;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [PWM_WIDTH-1:0] duty;
    logic [PWM_WIDTH-1:0] duty_step;
    logic [PWM_WIDTH:0]   duty_sum;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [RAMP_W-1:0]    ramp_cnt;
    logic [DEAD_W-1:0]    dead_cnt;

    logic       valve_in_q;
    logic       valve_out_q;
    logic       motor_en_q;
    logic       motor_dir_q;
    logic       motor_pwm_q;
    logic [2:0] fault_code_q;

    assign fill  = act.ctrl_fill;
    assign drain = act.ctrl_release;
    assign fwd   = act.ctrl_forward;
    assign rev   = act.ctrl_reverse;

    // A fwd+rev conflict is treated as no request at all.
    assign req         = fwd ^ rev;
    assign conflict    = fwd & rev;
    assign valve_clash = fill & drain;
    assign dir_change  = req & (fwd != motor_dir_q);
    assign ramp_tick   = (ramp_cnt == RAMP_LAST);

    assign duty_sum  = {1'b0, duty} + {1'b0, RAMP_STEP};
    assign duty_step = (duty_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum[PWM_WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (!req || dir_change) begin
                    state_nxt = ST_BRAKE;
                end else if ((ramp_tick ? duty_step : duty) == DUTY_MAX) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!req || dir_change) begin
                    state_nxt = ST_BRAKE;
                end
            end
            ST_BRAKE: begin
                if (dead_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef ACT_FILL_TIMEOUT_EN
    localparam int unsigned FILL_W = $clog2(FILL_TIMEOUT + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_TIMEOUT - 1);

    logic [FILL_W-1:0] fill_cnt;
    logic              fill_lock;

    // Closing edge happens on the cycle the FILL_TIMEOUT-th open cycle is seen.
    assign fill_timeout = valve_in_q && (fill_cnt == FILL_LAST);
    assign fill_block   = fill_lock | fill_timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt  <= '0;
            fill_lock <= 1'b0;
        end else begin
            fill_cnt <= valve_in_q ? fill_cnt + 1'b1 : '0;
            if (fill_timeout) begin
                fill_lock <= 1'b1;
            end else if (!fill) begin
                fill_lock <= 1'b0;
            end
        end
    end
`else
    assign fill_timeout = 1'b0;
    assign fill_block   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valve_in_q   <= 1'b0;
            valve_out_q  <= 1'b0;
            fault_code_q <= '0;
        end else begin
            valve_in_q   <= fill & ~drain & ~fill_block;
            valve_out_q  <= drain & ~fill;
            // A new event in the same cycle as clr_fault keeps its bit set.
            fault_code_q <= (act.clr_fault ? 3'b000 : fault_code_q)
                          | {fill_timeout, conflict, valve_clash};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            duty        <= '0;
            ramp_cnt    <= '0;
            dead_cnt    <= '0;
            pwm_cnt     <= '0;
            motor_en_q  <= 1'b0;
            motor_dir_q <= 1'b0;
            motor_pwm_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            motor_en_q  <= (state_nxt == ST_RAMP) || (state_nxt == ST_RUN);
            pwm_cnt     <= pwm_cnt + 1'b1;
            motor_pwm_q <= motor_en_q & (pwm_cnt < duty);

            if (state_nxt == ST_BRAKE || state_nxt == ST_IDLE) begin
                duty     <= '0;
                ramp_cnt <= '0;
            end else if (state == ST_IDLE) begin
                duty        <= '0;
                ramp_cnt    <= '0;
                motor_dir_q <= fwd;
            end else if (state == ST_RAMP) begin
                if (ramp_tick) begin
                    duty     <= duty_step;
                    ramp_cnt <= '0;
                end else begin
                    ramp_cnt <= ramp_cnt + 1'b1;
                end
            end

            if (state != ST_BRAKE && state_nxt == ST_BRAKE) begin
                dead_cnt <= DEAD_LAST;
            end else if (dead_cnt != '0) begin
                dead_cnt <= dead_cnt - 1'b1;
            end
        end
    end

    assign act.valve_in   = valve_in_q;
    assign act.valve_out  = valve_out_q;
    assign act.motor_en   = motor_en_q;
    assign act.motor_dir  = motor_dir_q;
    assign act.motor_pwm  = motor_pwm_q;
    assign act.fault_code = fault_code_q;
    assign act.fault      = |fault_code_q;

endmodule

// File: tb/tb_actuator_driver.sv
// Directed self-checking bench for actuator_driver; outputs are sampled on the falling edge.
// Build with ACT_FILL_TIMEOUT_EN defined to exercise the fill timeout with FILL_TIMEOUT=8.
module tb_actuator_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned pc;

    actuator_if bus ();

    actuator_driver #(.FILL_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .act   (bus)
    );

    always #5 clk = ~clk;

    // Reference for the free-running PWM counter, used to predict motor_pwm during the ramp.
    always @(posedge clk) begin
        if (!rst_n) pc <= 0;
        else        pc <= (pc + 1) % 256;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ctrl_fill    = 1'b0;
        bus.ctrl_release = 1'b0;
        bus.ctrl_forward = 1'b0;
        bus.ctrl_reverse = 1'b0;
        bus.clr_fault    = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.valve_in, bus.valve_out, bus.motor_en, bus.motor_dir, bus.motor_pwm,
             bus.fault, bus.fault_code} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 000000000", {bus.valve_in, bus.valve_out,
                     bus.motor_en, bus.motor_dir, bus.motor_pwm, bus.fault, bus.fault_code});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_valves();
        @(negedge clk);
        bus.ctrl_fill = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.valve_in, bus.valve_out} !== 2'b10) begin
                miscompares++;
                $display("FAIL fill_open[%0d] got %b want 10", i, {bus.valve_in, bus.valve_out});
            end
        end
        bus.ctrl_fill = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.valve_in, bus.valve_out} !== 2'b00) begin
            miscompares++;
            $display("FAIL fill_close got %b want 00", {bus.valve_in, bus.valve_out});
        end
        bus.ctrl_release = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.valve_in, bus.valve_out, bus.fault} !== 3'b010) begin
            miscompares++;
            $display("FAIL drain_open got %b want 010", {bus.valve_in, bus.valve_out, bus.fault});
        end
        bus.ctrl_fill = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.valve_in, bus.valve_out, bus.fault, bus.fault_code} !== 6'b001001) begin
            miscompares++;
            $display("FAIL valve_clash got %b want 001001",
                     {bus.valve_in, bus.valve_out, bus.fault, bus.fault_code});
        end
        bus.ctrl_fill    = 1'b0;
        bus.ctrl_release = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.fault, bus.fault_code} !== 4'b1001) begin
            miscompares++;
            $display("FAIL fault_sticky got %b want 1001", {bus.fault, bus.fault_code});
        end
        bus.clr_fault = 1'b1;
        @(negedge clk);
        bus.clr_fault = 1'b0;
        vectors++;
        if ({bus.fault, bus.fault_code} !== 4'b0000) begin
            miscompares++;
            $display("FAIL fault_clear got %b want 0000", {bus.fault, bus.fault_code});
        end
    endtask

    task automatic test_ramp();
        int          hi_act;
        int          hi_exp;
        int          hi_early;
        int          en_low;
        int          run_hi;
        int          prev_duty;
        int unsigned prev_pc;
        bit          prev_en;
        bit          exp_pwm;
        hi_act = 0; hi_exp = 0; hi_early = 0; en_low = 0; run_hi = 0;
        @(negedge clk);
        prev_en   = 1'b0;
        prev_pc   = pc;
        prev_duty = 0;
        bus.ctrl_forward = 1'b1;
        for (int t = 1; t <= 961; t++) begin
            @(negedge clk);
            exp_pwm = prev_en && (int'(prev_pc) < prev_duty);
            if (bus.motor_pwm === 1'b1) begin
                hi_act++;
                if (t <= 65) hi_early++;
            end
            if (exp_pwm) hi_exp++;
            if (bus.motor_en !== 1'b1) en_low++;
            prev_en   = 1'b1;
            prev_pc   = pc;
            prev_duty = ((t - 1) / 64) * 16;
            if (prev_duty > 240) prev_duty = 240;
        end
        vectors++;
        if (hi_early !== 0) begin
            miscompares++;
            $display("FAIL ramp_first_step_zero high_cycles=%0d want 0", hi_early);
        end
        vectors++;
        if (en_low !== 0) begin
            miscompares++;
            $display("FAIL ramp_motor_en low_cycles=%0d want 0", en_low);
        end
        vectors++;
        if (bus.motor_dir !== 1'b1) begin
            miscompares++;
            $display("FAIL ramp_dir got %b want 1", bus.motor_dir);
        end
        vectors++;
        if (hi_act !== hi_exp) begin
            miscompares++;
            $display("FAIL ramp_pwm_profile high_cycles=%0d want %0d", hi_act, hi_exp);
        end
        for (int t = 0; t < 256; t++) begin
            @(negedge clk);
            if (bus.motor_pwm === 1'b1) run_hi++;
        end
        vectors++;
        if (run_hi !== 240) begin
            miscompares++;
            $display("FAIL run_pwm_duty high_cycles=%0d want 240", run_hi);
        end
    endtask

    task automatic test_reversal();
        int en_low;
        int hi;
        en_low = 0; hi = 0;
        bus.ctrl_forward = 1'b0;
        bus.ctrl_reverse = 1'b1;
        for (int s = 1; s <= 17; s++) begin
            @(negedge clk);
            if (bus.motor_en === 1'b0) en_low++;
            if (s >= 2 && bus.motor_pwm === 1'b1) hi++;
        end
        vectors++;
        if (en_low !== 17) begin
            miscompares++;
            $display("FAIL brake_deadtime low_cycles=%0d want 17", en_low);
        end
        @(negedge clk);
        vectors++;
        if ({bus.motor_en, bus.motor_dir} !== 2'b10) begin
            miscompares++;
            $display("FAIL reverse_start got %b want 10", {bus.motor_en, bus.motor_dir});
        end
        for (int s = 19; s <= 82; s++) begin
            @(negedge clk);
            if (bus.motor_pwm === 1'b1) hi++;
        end
        vectors++;
        if (hi !== 0) begin
            miscompares++;
            $display("FAIL ramp_restart_duty high_cycles=%0d want 0", hi);
        end
        bus.ctrl_reverse = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if ({bus.motor_en, bus.motor_pwm} !== 2'b00) begin
            miscompares++;
            $display("FAIL stop_after_release got %b want 00", {bus.motor_en, bus.motor_pwm});
        end
    endtask

    task automatic test_conflict();
        int en_low;
        en_low = 0;
        bus.clr_fault = 1'b1;
        @(negedge clk);
        bus.clr_fault    = 1'b0;
        bus.ctrl_forward = 1'b1;
        bus.ctrl_reverse = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.motor_en === 1'b0) en_low++;
        end
        vectors++;
        if (en_low !== 5) begin
            miscompares++;
            $display("FAIL conflict_motor_off low_cycles=%0d want 5", en_low);
        end
        vectors++;
        if ({bus.fault, bus.fault_code} !== 4'b1010) begin
            miscompares++;
            $display("FAIL conflict_code got %b want 1010", {bus.fault, bus.fault_code});
        end
        bus.clr_fault = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.fault_code !== 3'b010) begin
            miscompares++;
            $display("FAIL conflict_clr_loses got %b want 010", bus.fault_code);
        end
        bus.ctrl_forward = 1'b0;
        bus.ctrl_reverse = 1'b0;
        @(negedge clk);
        bus.clr_fault = 1'b0;
        vectors++;
        if ({bus.fault, bus.fault_code} !== 4'b0000) begin
            miscompares++;
            $display("FAIL conflict_cleared got %b want 0000", {bus.fault, bus.fault_code});
        end
    endtask

    task automatic test_reset_midway();
        @(negedge clk);
        bus.ctrl_forward = 1'b1;
        repeat (100) @(negedge clk);
        bus.ctrl_fill    = 1'b1;
        bus.ctrl_release = 1'b1;
        @(negedge clk);
        bus.ctrl_release = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.valve_in, bus.motor_en, bus.fault_code} !== 5'b11001) begin
            miscompares++;
            $display("FAIL pre_reset_state got %b want 11001",
                     {bus.valve_in, bus.motor_en, bus.fault_code});
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.valve_in, bus.valve_out, bus.motor_en, bus.motor_dir, bus.motor_pwm,
             bus.fault, bus.fault_code} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_mid_ramp got %b want 000000000", {bus.valve_in, bus.valve_out,
                     bus.motor_en, bus.motor_dir, bus.motor_pwm, bus.fault, bus.fault_code});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.motor_en, bus.motor_dir} !== 2'b11) begin
            miscompares++;
            $display("FAIL ramp_after_reset got %b want 11", {bus.motor_en, bus.motor_dir});
        end
        repeat (10) @(negedge clk);
        bus.ctrl_forward = 1'b0;
        bus.ctrl_fill    = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (bus.motor_en !== 1'b0) begin
            miscompares++;
            $display("FAIL brake_entered got %b want 0", bus.motor_en);
        end
        rst_n = 1'b0;
        bus.ctrl_forward = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.valve_in, bus.valve_out, bus.motor_en, bus.motor_dir, bus.motor_pwm,
             bus.fault, bus.fault_code} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_mid_brake got %b want 000000000", {bus.valve_in, bus.valve_out,
                     bus.motor_en, bus.motor_dir, bus.motor_pwm, bus.fault, bus.fault_code});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.motor_en !== 1'b1) begin
            miscompares++;
            $display("FAIL no_deadtime_after_reset got %b want 1", bus.motor_en);
        end
        bus.ctrl_forward = 1'b0;
        repeat (20) @(negedge clk);
    endtask

`ifdef ACT_FILL_TIMEOUT_EN
    task automatic test_fill_timeout();
        int ones;
        ones = 0;
        bus.ctrl_fill = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.valve_in === 1'b1) ones++;
        end
        vectors++;
        if (ones !== 8) begin
            miscompares++;
            $display("FAIL fill_open_window open_cycles=%0d want 8", ones);
        end
        @(negedge clk);
        vectors++;
        if ({bus.valve_in, bus.fault_code[2]} !== 2'b01) begin
            miscompares++;
            $display("FAIL fill_timeout_close got %b want 01", {bus.valve_in, bus.fault_code[2]});
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.valve_in !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_locked got %b want 0", bus.valve_in);
        end
        bus.ctrl_fill = 1'b0;
        @(negedge clk);
        bus.ctrl_fill = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.valve_in !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_reopen got %b want 1", bus.valve_in);
        end
        bus.ctrl_fill = 1'b0;
        @(negedge clk);
    endtask
`else
    task automatic test_fill_timeout();
        int ones;
        ones = 0;
        bus.ctrl_fill = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.valve_in === 1'b1) ones++;
        end
        vectors++;
        if ({ones, bus.fault_code[2]} !== {32'd20, 1'b0}) begin
            miscompares++;
            $display("FAIL fill_unlimited open_cycles=%0d code2=%b want 20 and 0",
                     ones, bus.fault_code[2]);
        end
        bus.ctrl_fill = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_valves();
        test_ramp();
        test_reversal();
        test_conflict();
        test_reset_midway();
        test_fill_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
